pri_arb_mux: RTL and testbench

- Parametrised successor to the team's 4:1 select block: N-channel request arbiter plus data mux with a registered output stage.
- Each channel presents a request and a DATA_W-bit word. The block picks one winner per transfer and acknowledges it.
- The winner's word and index are held in an output register governed by a valid/ready handshake.
- Sits between multiple producers and a single downstream consumer.

---
 rtl/pri_arb_mux.sv | 160 ++++++++++++++++
 tb/tb_pri_arb_mux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pri_arb_mux.sv
// pri_arb_mux: N-channel request arbiter with a data mux feeding a registered
// valid/ready output stage. One winner per transfer is acknowledged with oAck.
//
// Build option: define PRI_ARB_RR_EN for round-robin selection starting at an
// internal pointer. Without it, selection is fixed priority (channel 0 highest)
// and the pointer does not exist. The port list is identical in both builds.
module pri_arb_mux #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned IDX_W  = 2
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic [N_CH-1:0]        iReq,
    input  logic [N_CH*DATA_W-1:0] iData,
    output logic [N_CH-1:0]        oAck,
    output logic                   oValid,
    output logic [DATA_W-1:0]      oData,
    output logic [IDX_W-1:0]       oIdx,
    input  logic                   iReady,
    output logic [7:0]             oBusyCnt
);

    // Elaboration-time parameter sanity
    if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
        $error("pri_arb_mux: N_CH must be in 2..16");
    end
    if (IDX_W != $clog2(N_CH)) begin : g_bad_idx_w
        $error("pri_arb_mux: IDX_W must equal ceil(log2(N_CH))");
    end

    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           busy_q, busy_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [N_CH-1:0]      win_onehot;
    logic [DATA_W-1:0]    win_data;
    logic [IDX_W-1:0]     cand;
    logic                 load;

`ifdef PRI_ARB_RR_EN
    logic [IDX_W-1:0]     rptr_q, rptr_d;
    int unsigned          rr_sum;
    int unsigned          rptr_nxt;
`endif

    // Winner search: first asserted request, scanning from the search base
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = '0;
`ifdef PRI_ARB_RR_EN
        rr_sum     = 0;
`endif
        for (int unsigned k = 0; k < N_CH; k++) begin
`ifdef PRI_ARB_RR_EN
            // Wrap the scan modulo N_CH starting at the round-robin pointer
            rr_sum = 32'(rptr_q) + k;
            if (rr_sum >= N_CH) begin
                rr_sum = rr_sum - N_CH;
            end
            cand = IDX_W'(rr_sum);
`else
            cand = IDX_W'(k);
`endif
            if (!win_found && iReq[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

    // Data mux driven by the one-hot winner
    always_comb begin
        win_data = '0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            if (win_onehot[j]) begin
                win_data = iData[j*DATA_W +: DATA_W];
            end
        end
    end

    // Load when something is requested and the output slot is free or draining
    always_comb begin
        load = (|iReq) && (!valid_q || iReady);
        // No acknowledge may escape while reset is held
        oAck = (load && iRst_n) ? win_onehot : '0;
    end

    // Output register next state, including same-edge pop-and-replace
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = win_data;
            idx_d   = win_idx;
        end else if (valid_q && iReady) begin
            valid_d = 1'b0;
        end
    end

    // Back-pressure monitor: saturating count of stalled cycles
    always_comb begin
        busy_d = busy_q;
        if (valid_q && !iReady && (busy_q != 8'hFF)) begin
            busy_d = busy_q + 8'd1;
        end
    end

`ifdef PRI_ARB_RR_EN
    // Pointer moves just past the winner on every load, otherwise holds
    always_comb begin
        rptr_d   = rptr_q;
        rptr_nxt = 32'(win_idx) + 1;
        if (rptr_nxt >= N_CH) begin
            rptr_nxt = 0;
        end
        if (load) begin
            rptr_d = IDX_W'(rptr_nxt);
        end
    end

    // Round-robin pointer state
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
        end
    end
`endif

    // Output register and busy counter state
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 8'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign oValid   = valid_q;
    assign oData    = data_q;
    assign oIdx     = idx_q;
    assign oBusyCnt = busy_q;

endmodule

// File: tb/tb_pri_arb_mux.sv
// Scoreboard bench for pri_arb_mux (N_CH=4, DATA_W=8). The driver keeps a
// transfer-level model of producers and the output slot; every expected
// transfer is queued and a monitor pops it when the DUT hands a word over.
module tb_pri_arb_mux;

    logic        iClk;
    logic        iRst_n;
    logic [3:0]  iReq;
    logic [31:0] iData;
    logic [3:0]  oAck;
    logic        oValid;
    logic [7:0]  oData;
    logic [1:0]  oIdx;
    logic        iReady;
    logic [7:0]  oBusyCnt;

    pri_arb_mux #(
        .N_CH   (4),
        .DATA_W (8),
        .IDX_W  (2)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iReq     (iReq),
        .iData    (iData),
        .oAck     (oAck),
        .oValid   (oValid),
        .oData    (oData),
        .oIdx     (oIdx),
        .iReady   (iReady),
        .oBusyCnt (oBusyCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [3:0] pend;
    logic [7:0] pdata [4];
    bit         m_valid;
    int         m_busy;
    int         m_ptr;
    logic [9:0] sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arbitration rule: first pending channel found scanning up from ptr, wrapping
    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (ptr + k) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One clock of stimulus; entered and left at posedge+2
    task automatic step(input bit rdy, input logic [3:0] raise, input logic [31:0] words);
        logic [3:0] req;
        int         w;
        bit         ld;
        logic [31:0] exp_ack;
        for (int k = 0; k < 4; k++) begin
            if (!pend[k] && raise[k]) begin
                pend[k]  = 1'b1;
                pdata[k] = words[k*8 +: 8];
            end
        end
        req     = pend;
        w       = pick(req, m_ptr);
        ld      = (req != 4'd0) && (!m_valid || rdy);
        exp_ack = ld ? (32'd1 << w) : 32'd0;
        iReq    = req;
        iData   = {pdata[3], pdata[2], pdata[1], pdata[0]};
        iReady  = rdy;
        #3;
        chk("ack", {28'd0, oAck}, exp_ack);
        chk("valid", {31'd0, oValid}, {31'd0, m_valid});
        chk("busy_cnt", {24'd0, oBusyCnt}, m_busy);
        if (m_valid && !rdy && m_busy < 255) m_busy++;
        if (ld) begin
            sb.push_back({w[1:0], pdata[w]});
            pend[w] = 1'b0;
            m_valid = 1'b1;
`ifdef PRI_ARB_RR_EN
            m_ptr = (w + 1) % 4;
`endif
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge iClk);
        #2;
    endtask

    // Monitor: every handshake must hand over the oldest expected word
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge iClk);
            if (iRst_n === 1'b1 && oValid === 1'b1 && iReady === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got word %0h idx %0d expected none at %0t",
                             oData, oIdx, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {24'd0, oData}, {24'd0, e[7:0]});
                    chk("out_idx", {30'd0, oIdx}, {30'd0, e[9:8]});
                end
            end
        end
    end

    initial begin
        pend    = '0;
        for (int k = 0; k < 4; k++) pdata[k] = 8'd0;
        m_valid = 1'b0;
        m_busy  = 0;
        m_ptr   = 0;
        iRst_n  = 1'b0;
        iReq    = '0;
        iData   = '0;
        iReady  = 1'b0;

        // Reset held for 3 cycles; acks must stay low even with requests up
        for (int i = 0; i < 3; i++) begin
            @(posedge iClk);
            #2;
            iReq = (i == 1) ? 4'hF : 4'h0;
            #3;
            chk("rst_ack", {28'd0, oAck}, 32'd0);
            chk("rst_valid", {31'd0, oValid}, 32'd0);
            chk("rst_data", {24'd0, oData}, 32'd0);
            chk("rst_idx", {30'd0, oIdx}, 32'd0);
            chk("rst_busy", {24'd0, oBusyCnt}, 32'd0);
        end
        @(posedge iClk);
        #2;
        iRst_n = 1'b1;
        step(1'b1, 4'b0000, 32'd0);
        step(1'b1, 4'b0000, 32'd0);

        // Single request on channel 2
        step(1'b1, 4'b0100, 32'h00A5_0000);
        step(1'b1, 4'b0000, 32'd0);

        // Contention 1011, producers drop after ack
        step(1'b1, 4'b1011, 32'h4433_2211);
        repeat (3) step(1'b1, 4'b0000, 32'd0);

        // Back-pressure: 5 stalled cycles, then same-edge replacement
        step(1'b1, 4'b0001, 32'h0000_00C3);
        repeat (5) step(1'b0, 4'b0010, 32'h0000_5A00);
        step(1'b1, 4'b0000, 32'd0);
        step(1'b1, 4'b0000, 32'd0);

        // Build busy count to 10 with a word stuck in the register
        step(1'b1, 4'b1000, 32'h7E00_0000);
        repeat (5) step(1'b0, 4'b0000, 32'd0);
        chk("busy_before_rst", {24'd0, oBusyCnt}, 32'd10);

        // Async reset between edges: everything clears without a clock
        iRst_n = 1'b0;
        iReq   = 4'b0001;
        #1;
        chk("arst_valid", {31'd0, oValid}, 32'd0);
        chk("arst_data", {24'd0, oData}, 32'd0);
        chk("arst_idx", {30'd0, oIdx}, 32'd0);
        chk("arst_busy", {24'd0, oBusyCnt}, 32'd0);
        chk("arst_ack", {28'd0, oAck}, 32'd0);
        pend    = '0;
        m_valid = 1'b0;
        m_busy  = 0;
        m_ptr   = 0;
        sb.delete();
        @(posedge iClk);
        #2;
        iRst_n = 1'b1;

        // All channels requesting continuously
        repeat (8) step(1'b1, 4'b1111, $urandom());
        step(1'b1, 4'b0000, 32'd0);
        // Channel 3 alone
        step(1'b1, 4'b1000, 32'h9100_0000);
        step(1'b1, 4'b0000, 32'd0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom());
        end
        repeat (6) step(1'b1, 4'b0000, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
